// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by the execute stage and its ALU.
package y86_pkg;

   localparam int W = 64;

   localparam logic [3:0] RNONE = 4'hF;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_XOR = 4'h3;

   localparam logic [3:0] C_YES = 4'h0;
   localparam logic [3:0] C_LE  = 4'h1;
   localparam logic [3:0] C_L   = 4'h2;
   localparam logic [3:0] C_E   = 4'h3;
   localparam logic [3:0] C_NE  = 4'h4;
   localparam logic [3:0] C_GE  = 4'h5;
   localparam logic [3:0] C_G   = 4'h6;

   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SADR = 3'd2;
   localparam logic [2:0] SINS = 3'd3;
   localparam logic [2:0] SHLT = 3'd4;

   // Branch / conditional-move predicate; cc is {ZF,SF,OF}.
   function automatic logic cond_eval(input logic [3:0] ifun, input logic [2:0] cc);
      logic zf, sf, of;
      zf = cc[2];
      sf = cc[1];
      of = cc[0];
      case (ifun)
         C_YES:   cond_eval = 1'b1;
         C_LE:    cond_eval = (sf ^ of) | zf;
         C_L:     cond_eval = sf ^ of;
         C_E:     cond_eval = zf;
         C_NE:    cond_eval = ~zf;
         C_GE:    cond_eval = ~(sf ^ of);
         C_G:     cond_eval = ~(sf ^ of) & ~zf;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_alu.sv
// Combinational Y86-64 ALU: valE = B op A, plus {ZF,SF,OF} for the result.
module pipe_alu
   import y86_pkg::*;
(
   input  logic [W-1:0] alu_a,
   input  logic [W-1:0] alu_b,
   input  logic [3:0]   alu_fun,
   output logic [W-1:0] val_e,
   output logic [2:0]   flags
);

   logic of_bit;

   // Select the operation; unknown function codes produce zero with OF clear.
   always_comb begin
      val_e  = '0;
      of_bit = 1'b0;
      case (alu_fun)
         ALU_ADD: begin
            val_e  = alu_b + alu_a;
            of_bit = (alu_a[W-1] == alu_b[W-1]) && (val_e[W-1] != alu_a[W-1]);
         end
         ALU_SUB: begin
            val_e  = alu_b - alu_a;
            of_bit = (alu_b[W-1] != alu_a[W-1]) && (val_e[W-1] != alu_b[W-1]);
         end
         ALU_AND: val_e = alu_b & alu_a;
         ALU_XOR: val_e = alu_b ^ alu_a;
         default: val_e = '0;
      endcase
   end

   assign flags = {(val_e == '0), val_e[W-1], of_bit};

endmodule

// File: rtl/pipe_execute.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and cnd.
module pipe_execute
   import y86_pkg::*;
(
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         stall_i,
   input  logic         bubble_i,
   input  logic         set_cc_i,
   input  logic [3:0]   D_icode_i,
   input  logic [3:0]   D_ifun_i,
   input  logic [2:0]   D_stat_i,
   input  logic [63:0]  D_valA_i,
   input  logic [63:0]  D_valB_i,
   input  logic [63:0]  D_valC_i,
   input  logic [3:0]   D_dstE_i,
   input  logic [3:0]   D_dstM_i,
   input  logic [3:0]   D_srcA_i,
   input  logic [3:0]   D_srcB_i,
   output logic [3:0]   E_icode_o,
   output logic [3:0]   E_ifun_o,
   output logic [2:0]   E_stat_o,
   output logic [63:0]  E_valA_o,
   output logic [3:0]   E_dstM_o,
   output logic [3:0]   E_srcA_o,
   output logic [3:0]   E_srcB_o,
   output logic [63:0]  e_valE_o,
   output logic         e_cnd_o,
   output logic [3:0]   e_dstE_o,
   output logic [2:0]   cc_o
);

   logic [3:0]   icode_q, icode_d;
   logic [3:0]   ifun_q, ifun_d;
   logic [2:0]   stat_q, stat_d;
   logic [W-1:0] val_a_q, val_a_d;
   logic [W-1:0] val_b_q, val_b_d;
   logic [W-1:0] val_c_q, val_c_d;
   logic [3:0]   dst_e_q, dst_e_d;
   logic [3:0]   dst_m_q, dst_m_d;
   logic [3:0]   src_a_q, src_a_d;
   logic [3:0]   src_b_q, src_b_d;
   logic [2:0]   cc_q, cc_d;

   logic [W-1:0] alu_a;
   logic [W-1:0] alu_b;
   logic [3:0]   alu_fun;
   logic [W-1:0] alu_val_e;
   logic [2:0]   alu_flags;
   logic         cnd;

   // E register next value: bubble beats stall, stall holds, otherwise load decode.
   always_comb begin
      icode_d = icode_q;
      ifun_d  = ifun_q;
      stat_d  = stat_q;
      val_a_d = val_a_q;
      val_b_d = val_b_q;
      val_c_d = val_c_q;
      dst_e_d = dst_e_q;
      dst_m_d = dst_m_q;
      src_a_d = src_a_q;
      src_b_d = src_b_q;
      if (bubble_i) begin
         icode_d = INOP;
         ifun_d  = 4'h0;
         stat_d  = SAOK;
         val_a_d = '0;
         val_b_d = '0;
         val_c_d = '0;
         dst_e_d = RNONE;
         dst_m_d = RNONE;
         src_a_d = RNONE;
         src_b_d = RNONE;
      end else if (!stall_i) begin
         icode_d = D_icode_i;
         ifun_d  = D_ifun_i;
         stat_d  = D_stat_i;
         val_a_d = D_valA_i;
         val_b_d = D_valB_i;
         val_c_d = D_valC_i;
         dst_e_d = D_dstE_i;
         dst_m_d = D_dstM_i;
         src_a_d = D_srcA_i;
         src_b_d = D_srcB_i;
      end
   end

   // ALU operand and function selection from the registered instruction.
   always_comb begin
      alu_a = '0;
      alu_b = '0;
      case (icode_q)
         IRRMOVQ, IOPQ:           alu_a = val_a_q;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = val_c_q;
         ICALL, IPUSHQ:           alu_a = -64'sd8;
         IRET, IPOPQ:             alu_a = 64'd8;
         default:                 alu_a = '0;
      endcase
      case (icode_q)
         IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = val_b_q;
         default:                                            alu_b = '0;
      endcase
      alu_fun = (icode_q == IOPQ) ? ifun_q : ALU_ADD;
   end

   pipe_alu u_alu (
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_fun (alu_fun),
      .val_e   (alu_val_e),
      .flags   (alu_flags)
   );

   // CC captures the OPq flags only when the stage is advancing and control allows it.
   always_comb begin
      cc_d = cc_q;
      if (icode_q == IOPQ && set_cc_i && !stall_i) begin
         cc_d = alu_flags;
      end
   end

   // State registers with synchronous reset taking priority over everything.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         icode_q <= INOP;
         ifun_q  <= 4'h0;
         stat_q  <= SAOK;
         val_a_q <= '0;
         val_b_q <= '0;
         val_c_q <= '0;
         dst_e_q <= RNONE;
         dst_m_q <= RNONE;
         src_a_q <= RNONE;
         src_b_q <= RNONE;
         cc_q    <= 3'b100;
      end else begin
         icode_q <= icode_d;
         ifun_q  <= ifun_d;
         stat_q  <= stat_d;
         val_a_q <= val_a_d;
         val_b_q <= val_b_d;
         val_c_q <= val_c_d;
         dst_e_q <= dst_e_d;
         dst_m_q <= dst_m_d;
         src_a_q <= src_a_d;
         src_b_q <= src_b_d;
         cc_q    <= cc_d;
      end
   end

   // Condition uses the CC value held before any write this cycle.
   assign cnd = cond_eval(ifun_q, cc_q);

   assign E_icode_o = icode_q;
   assign E_ifun_o  = ifun_q;
   assign E_stat_o  = stat_q;
   assign E_valA_o  = val_a_q;
   assign E_dstM_o  = dst_m_q;
   assign E_srcA_o  = src_a_q;
   assign E_srcB_o  = src_b_q;
   assign e_valE_o  = alu_val_e;
   assign e_cnd_o   = cnd;
   assign e_dstE_o  = (icode_q == IRRMOVQ && !cnd) ? RNONE : dst_e_q;
   assign cc_o      = cc_q;

endmodule

// File: tb/tb_pipe_execute.sv
// Self-checking bench for pipe_execute: vector table through a scoreboard,
// then hand sequences for CC timing, stall, bubble and reset.
module tb_pipe_execute;

   logic         clk;
   logic         rst_i, stall_i, bubble_i, set_cc_i;
   logic [3:0]   d_icode, d_ifun;
   logic [2:0]   d_stat;
   logic [63:0]  d_vala, d_valb, d_valc;
   logic [3:0]   d_dste, d_dstm, d_srca, d_srcb;
   logic [3:0]   E_icode, E_ifun;
   logic [2:0]   E_stat;
   logic [63:0]  E_valA;
   logic [3:0]   E_dstM, E_srcA, E_srcB;
   logic [63:0]  e_valE;
   logic         e_cnd;
   logic [3:0]   e_dstE;
   logic [2:0]   cc;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [2:0]  stat;
      logic [63:0] va;
      logic [63:0] vb;
      logic [63:0] vc;
      logic [3:0]  dste;
      logic [63:0] exp_vale;
      logic        exp_cnd;
      logic [3:0]  exp_dste;
   } vec_t;

   typedef struct {
      logic [3:0]  icode;
      logic [2:0]  stat;
      logic [63:0] vala;
      logic [3:0]  srca;
      logic [63:0] vale;
      logic        cnd;
      logic [3:0]  dste;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   pipe_execute dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .stall_i   (stall_i),
      .bubble_i  (bubble_i),
      .set_cc_i  (set_cc_i),
      .D_icode_i (d_icode),
      .D_ifun_i  (d_ifun),
      .D_stat_i  (d_stat),
      .D_valA_i  (d_vala),
      .D_valB_i  (d_valb),
      .D_valC_i  (d_valc),
      .D_dstE_i  (d_dste),
      .D_dstM_i  (d_dstm),
      .D_srcA_i  (d_srca),
      .D_srcB_i  (d_srcb),
      .E_icode_o (E_icode),
      .E_ifun_o  (E_ifun),
      .E_stat_o  (E_stat),
      .E_valA_o  (E_valA),
      .E_dstM_o  (E_dstM),
      .E_srcA_o  (E_srcA),
      .E_srcB_o  (E_srcB),
      .e_valE_o  (e_valE),
      .e_cnd_o   (e_cnd),
      .e_dstE_o  (e_dstE),
      .cc_o      (cc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                        input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                        input logic [3:0] dste, input logic [3:0] id, input logic scc);
      d_icode  = icode;
      d_ifun   = ifun;
      d_stat   = stat;
      d_vala   = va;
      d_valb   = vb;
      d_valc   = vc;
      d_dste   = dste;
      d_srca   = id;
      d_srcb   = id + 4'd1;
      d_dstm   = ~id;
      set_cc_i = scc;
   endtask

   task automatic add_vec(input logic [3:0] icode, input logic [3:0] ifun, input logic [2:0] stat,
                          input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc,
                          input logic [3:0] dste, input logic [63:0] ev, input logic ec,
                          input logic [3:0] ed);
      vec_t v;
      v.icode = icode; v.ifun = ifun; v.stat = stat;
      v.va = va; v.vb = vb; v.vc = vc; v.dste = dste;
      v.exp_vale = ev; v.exp_cnd = ec; v.exp_dste = ed;
      vecs.push_back(v);
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; bubble_i = 1'b0;
      drive(4'h6, 4'h0, 3'd1, 64'h55, 64'h66, 64'h77, 4'h2, 4'h3, 1'b1);

      // Reset for two cycles
      tick();
      tick();
      chk("rst_icode", {60'd0, E_icode}, 64'h1);
      chk("rst_dstE",  {60'd0, e_dstE}, 64'hF);
      chk("rst_cc",    {61'd0, cc}, 64'h4);
      chk("rst_valE",  e_valE, 64'h0);
      chk("rst_stat",  {61'd0, E_stat}, 64'h1);
      chk("rst_srcA",  {60'd0, E_srcA}, 64'hF);
      rst_i = 1'b0;

      // Vectors with CC = {ZF=1,SF=0,OF=0} throughout (set_cc_i low)
      add_vec(4'h6, 4'h1, 3'd1, 64'd5, 64'd5, 64'd0, 4'h2, 64'd0, 1'b1, 4'h2);
      add_vec(4'h6, 4'h0, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2,
              64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 4'h2);
      add_vec(4'h6, 4'h2, 3'd1, 64'hF0, 64'h3C, 64'd0, 4'h2, 64'h30, 1'b0, 4'h2);
      add_vec(4'h6, 4'h3, 3'd1, 64'hF0, 64'h3C, 64'd0, 4'h2, 64'hCC, 1'b1, 4'h2);
      add_vec(4'h6, 4'h5, 3'd1, 64'hF0, 64'h3C, 64'd0, 4'h2, 64'h0, 1'b1, 4'h2);
      add_vec(4'hA, 4'h0, 3'd1, 64'h9, 64'h100, 64'd0, 4'h4, 64'hF8, 1'b1, 4'h4);
      add_vec(4'hB, 4'h0, 3'd1, 64'h9, 64'h100, 64'd0, 4'h4, 64'h108, 1'b1, 4'h4);
      add_vec(4'h3, 4'h0, 3'd1, 64'h9, 64'h100, 64'h1234, 4'h3, 64'h1234, 1'b1, 4'h3);
      add_vec(4'h2, 4'h0, 3'd1, 64'h55, 64'h100, 64'h9, 4'h5, 64'h55, 1'b1, 4'h5);
      add_vec(4'h2, 4'h1, 3'd1, 64'h77, 64'h100, 64'h9, 4'h3, 64'h77, 1'b1, 4'h3);
      add_vec(4'h2, 4'h2, 3'd1, 64'h77, 64'h100, 64'h9, 4'h3, 64'h77, 1'b0, 4'hF);
      add_vec(4'h2, 4'h4, 3'd1, 64'h77, 64'h100, 64'h9, 4'h3, 64'h77, 1'b0, 4'hF);
      add_vec(4'h2, 4'h3, 3'd1, 64'h77, 64'h100, 64'h9, 4'h3, 64'h77, 1'b1, 4'h3);
      add_vec(4'h2, 4'h6, 3'd1, 64'h77, 64'h100, 64'h9, 4'h3, 64'h77, 1'b0, 4'hF);
      add_vec(4'h4, 4'h0, 3'd1, 64'h9, 64'h20, 64'h10, 4'hF, 64'h30, 1'b1, 4'hF);
      add_vec(4'h8, 4'h0, 3'd1, 64'h9, 64'h200, 64'h10, 4'h4, 64'h1F8, 1'b1, 4'h4);
      add_vec(4'h9, 4'h0, 3'd1, 64'h9, 64'h200, 64'h10, 4'h4, 64'h208, 1'b1, 4'h4);
      add_vec(4'h7, 4'h7, 3'd1, 64'h9, 64'h200, 64'h400, 4'hF, 64'h0, 1'b0, 4'hF);
      add_vec(4'h6, 4'h1, 3'd2, 64'd3, 64'd10, 64'd0, 4'h6, 64'd7, 1'b1, 4'h6);
      add_vec(4'h0, 4'h0, 3'd4, 64'h9, 64'h200, 64'h400, 4'hF, 64'h0, 1'b1, 4'hF);

      for (int i = 0; i < vecs.size(); i++) begin
         exp_t e;
         logic [3:0] id;
         id = i[3:0];
         drive(vecs[i].icode, vecs[i].ifun, vecs[i].stat, vecs[i].va, vecs[i].vb, vecs[i].vc,
               vecs[i].dste, id, 1'b0);
         e.icode = vecs[i].icode; e.stat = vecs[i].stat; e.vala = vecs[i].va; e.srca = id;
         e.vale = vecs[i].exp_vale; e.cnd = vecs[i].exp_cnd; e.dste = vecs[i].exp_dste;
         sb.push_back(e);
         tick();
         if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
         end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_icode", i), {60'd0, E_icode}, {60'd0, e.icode});
            chk($sformatf("v%0d_stat", i),  {61'd0, E_stat},  {61'd0, e.stat});
            chk($sformatf("v%0d_valA", i),  E_valA, e.vala);
            chk($sformatf("v%0d_srcA", i),  {60'd0, E_srcA},  {60'd0, e.srca});
            chk($sformatf("v%0d_valE", i),  e_valE, e.vale);
            chk($sformatf("v%0d_cnd", i),   {63'd0, e_cnd},   {63'd0, e.cnd});
            chk($sformatf("v%0d_dstE", i),  {60'd0, e_dstE},  {60'd0, e.dste});
            chk($sformatf("v%0d_cc", i),    {61'd0, cc}, 64'h4);
            $display("vec %0d icode=%0h ifun=%0h valE=%0h cnd=%0d dstE=%0h",
                     i, E_icode, E_ifun, e_valE, e_cnd, e_dstE);
         end
      end

      // addq 1+1 with set_cc: CC changes one edge after E loads it
      drive(4'h6, 4'h0, 3'd1, 64'd1, 64'd1, 64'd0, 4'h2, 4'h1, 1'b1);
      tick();
      chk("add_valE", e_valE, 64'd2);
      chk("add_cc_old", {61'd0, cc}, 64'h4);
      drive(4'h1, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1);
      tick();
      chk("add_cc_new", {61'd0, cc}, 64'h0);

      // cmovle with CC = 000: not taken
      drive(4'h2, 4'h1, 3'd1, 64'h77, 64'd0, 64'd0, 4'h3, 4'h1, 1'b0);
      tick();
      chk("cmovle0_cnd", {63'd0, e_cnd}, 64'd0);
      chk("cmovle0_dstE", {60'd0, e_dstE}, 64'hF);

      // subq with set_cc low leaves CC alone
      drive(4'h6, 4'h1, 3'd1, 64'd5, 64'd5, 64'd0, 4'h2, 4'h1, 1'b0);
      tick();
      chk("subq_nocc_valE", e_valE, 64'd0);
      drive(4'h1, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b0);
      tick();
      chk("subq_nocc_cc", {61'd0, cc}, 64'h0);

      // subq with set_cc: cnd in its own cycle still sees old CC
      drive(4'h6, 4'h1, 3'd1, 64'd5, 64'd5, 64'd0, 4'h2, 4'h1, 1'b1);
      tick();
      chk("subq_cnd_old", {63'd0, e_cnd}, 64'd0);
      chk("subq_cc_old", {61'd0, cc}, 64'h0);
      drive(4'h2, 4'h1, 3'd1, 64'h77, 64'd0, 64'd0, 4'h3, 4'h1, 1'b1);
      tick();
      chk("subq_cc_new", {61'd0, cc}, 64'h4);
      chk("cmovle1_cnd", {63'd0, e_cnd}, 64'd1);
      chk("cmovle1_dstE", {60'd0, e_dstE}, 64'h3);

      // addq overflow sets SF and OF
      drive(4'h6, 4'h0, 3'd1, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 4'h2, 4'h1, 1'b1);
      tick();
      chk("ovf_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFFE);
      drive(4'h1, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1);
      tick();
      chk("ovf_cc", {61'd0, cc}, 64'h3);

      // Stall holds every E field against new decode inputs
      drive(4'h3, 4'h0, 3'd1, 64'h11, 64'd0, 64'hABC, 4'h6, 4'h7, 1'b0);
      tick();
      drive(4'h6, 4'h3, 3'd2, 64'h1, 64'h2, 64'h3, 4'h9, 4'h9, 1'b0);
      stall_i = 1'b1;
      tick();
      chk("stall_icode", {60'd0, E_icode}, 64'h3);
      chk("stall_stat", {61'd0, E_stat}, 64'h1);
      chk("stall_valA", E_valA, 64'h11);
      chk("stall_valE", e_valE, 64'hABC);
      chk("stall_dstE", {60'd0, e_dstE}, 64'h6);
      chk("stall_srcA", {60'd0, E_srcA}, 64'h7);
      chk("stall_dstM", {60'd0, E_dstM}, 64'h8);
      stall_i = 1'b0;

      // Stall during OPq blocks the CC write until the stall releases
      drive(4'h6, 4'h1, 3'd1, 64'd5, 64'd5, 64'd0, 4'h2, 4'h1, 1'b1);
      tick();
      stall_i = 1'b1;
      tick();
      chk("stallcc_cc", {61'd0, cc}, 64'h3);
      chk("stallcc_icode", {60'd0, E_icode}, 64'h6);
      stall_i = 1'b0;
      drive(4'h1, 4'h0, 3'd1, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 1'b1);
      tick();
      chk("stallcc_release", {61'd0, cc}, 64'h4);

      // Stall plus bubble inserts a NOP
      drive(4'h6, 4'h0, 3'd2, 64'd3, 64'd4, 64'd5, 4'h2, 4'h5, 1'b0);
      stall_i = 1'b1;
      bubble_i = 1'b1;
      tick();
      chk("bubble_icode", {60'd0, E_icode}, 64'h1);
      chk("bubble_stat", {61'd0, E_stat}, 64'h1);
      chk("bubble_valA", E_valA, 64'h0);
      chk("bubble_dstE", {60'd0, e_dstE}, 64'hF);
      chk("bubble_srcA", {60'd0, E_srcA}, 64'hF);
      chk("bubble_valE", e_valE, 64'h0);
      stall_i = 1'b0;
      bubble_i = 1'b0;

      // Reset mid-instruction discards E and wins over a pending CC write
      drive(4'h6, 4'h0, 3'd1, 64'd1, 64'd1, 64'd0, 4'h2, 4'h1, 1'b1);
      tick();
      rst_i = 1'b1;
      tick();
      chk("midrst_icode", {60'd0, E_icode}, 64'h1);
      chk("midrst_cc", {61'd0, cc}, 64'h4);
      chk("midrst_dstE", {60'd0, e_dstE}, 64'hF);
      rst_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
